// File: rtl/clarvi_slice_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : clarvi_slice_pkg
//  Brief   : Shared types and constants for the part-sliced 64-bit ALU.
//  Revision: 1.0
// ============================================================================
package clarvi_slice_pkg;

    localparam int PART_WIDTH = 16;
    localparam int NUM_PARTS  = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_SLTU = 3'd6
    } alu_op_t;

    typedef logic [1:0] seq_state_t;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic op_is_compare(input alu_op_t op);
        return (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    // Subtract-style ops run as a + ~b + 1 across the parts.
    function automatic logic op_inverts_b(input alu_op_t op);
        return (op == OP_SUB) || op_is_compare(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clarvi_slice_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module  : clarvi_slice_alu_unit
//  Brief   : Combinational one-part ALU slice with carry in/out and overflow.
//  Revision: 1.0
// ============================================================================
module clarvi_slice_alu_unit
    import clarvi_slice_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH:0] sum;

    assign sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign carry_out = sum[WIDTH];
    // Signed overflow of this slice, meaningful only for the top part.
    assign overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result = sum[WIDTH-1:0];
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = sum[WIDTH-1:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/clarvi_slice_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module  : clarvi_slice_alu_seq
//  Brief   : Multi-cycle 64-bit ALU walking 16-bit register parts with carry.
//  Revision: 1.0
// ============================================================================
module clarvi_slice_alu_seq #(
    parameter int PART_WIDTH     = 16,
    parameter int NUM_PARTS      = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   op,
    input  logic [REG_ADDR_WIDTH-1:0]    rs1,
    input  logic [REG_ADDR_WIDTH-1:0]    rs2,
    input  logic [REG_ADDR_WIDTH-1:0]    rd,
    output logic                         busy,
    output logic                         done,
    output logic                         flag_zero,
    output logic                         flag_carry,
    output logic [$clog2(NUM_PARTS)-1:0] fetch_part,
    output logic [REG_ADDR_WIDTH-1:0]    fetch_register_1,
    output logic [REG_ADDR_WIDTH-1:0]    fetch_register_2,
    input  logic [PART_WIDTH-1:0]        data_in_1,
    input  logic [PART_WIDTH-1:0]        data_in_2,
    output logic [$clog2(NUM_PARTS)-1:0] write_part,
    output logic [REG_ADDR_WIDTH-1:0]    write_register,
    output logic [PART_WIDTH-1:0]        write_data,
    output logic                         write_enable
);
    import clarvi_slice_pkg::*;

    localparam int CTR_W = $clog2(NUM_PARTS);

    seq_state_t                state;
    alu_op_t                   op_reg;
    logic [REG_ADDR_WIDTH-1:0] rs1_reg;
    logic [REG_ADDR_WIDTH-1:0] rs2_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_reg;
    logic [CTR_W-1:0]          part_ctr;
    logic                      carry_reg;
    logic                      lt_reg;
    logic                      zero_acc;

    logic [PART_WIDTH-1:0]     alu_b;
    logic [PART_WIDTH-1:0]     alu_result;
    logic                      alu_carry;
    logic                      alu_ovf;
    logic                      last_part;
    logic                      accept;
    logic                      is_cmp;
    logic                      part_zero;

    assign is_cmp    = op_is_compare(op_reg);
    assign alu_b     = op_inverts_b(op_reg) ? ~data_in_2 : data_in_2;
    assign last_part = (part_ctr == CTR_W'(NUM_PARTS - 1));
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign part_zero = (alu_result == '0);

    clarvi_slice_alu_unit #(
        .WIDTH     (PART_WIDTH)
    ) u_alu (
        .a         (data_in_1),
        .b         (alu_b),
        .carry_in  (carry_reg),
        .op        (op_reg),
        .result    (alu_result),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            op_reg     <= OP_ADD;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            rd_reg     <= '0;
            part_ctr   <= '0;
            carry_reg  <= 1'b0;
            lt_reg     <= 1'b0;
            zero_acc   <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_reg    <= alu_op_t'(op);
                        rs1_reg   <= rs1;
                        rs2_reg   <= rs2;
                        rd_reg    <= rd;
                        part_ctr  <= '0;
                        carry_reg <= op_inverts_b(alu_op_t'(op));
                        zero_acc  <= 1'b1;
                        state     <= S_EXEC;
                    end else begin
                        state     <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    carry_reg <= alu_carry;
                    zero_acc  <= zero_acc & part_zero;
                    part_ctr  <= last_part ? '0 : part_ctr + 1'b1;
                    if (last_part) begin
                        flag_zero  <= zero_acc & part_zero;
                        flag_carry <= alu_carry;
                        // Unsigned: borrow is the inverted carry; signed: sign xor overflow.
                        lt_reg     <= (op_reg == OP_SLTU) ? ~alu_carry
                                                          : (alu_result[PART_WIDTH-1] ^ alu_ovf);
                        state      <= is_cmp ? S_WB : S_DONE;
                    end
                end
                S_WB: begin
                    part_ctr <= last_part ? '0 : part_ctr + 1'b1;
                    if (last_part) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy             = (state == S_EXEC) || (state == S_WB);
        done             = (state == S_DONE);
        fetch_part       = '0;
        fetch_register_1 = '0;
        fetch_register_2 = '0;
        write_part       = '0;
        write_register   = '0;
        write_data       = '0;
        write_enable     = 1'b0;
        if (busy) begin
            fetch_part       = part_ctr;
            fetch_register_1 = rs1_reg;
            fetch_register_2 = rs2_reg;
            write_part       = part_ctr;
            write_register   = rd_reg;
        end
        if (state == S_EXEC && !is_cmp) begin
            write_data   = alu_result;
            write_enable = (rd_reg != '0);
        end else if (state == S_WB) begin
            write_data   = (part_ctr == '0) ? {{(PART_WIDTH-1){1'b0}}, lt_reg} : '0;
            write_enable = (rd_reg != '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clarvi_slice_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_clarvi_slice_alu_seq
//  Brief   : Directed self-checking bench with a behavioural part-addressed regfile.
//  Revision: 1.0
// ============================================================================
module tb_clarvi_slice_alu_seq;
    import clarvi_slice_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        busy, done, flag_zero, flag_carry;
    logic [1:0]  fetch_part, write_part;
    logic [4:0]  fetch_register_1, fetch_register_2, write_register;
    logic [15:0] data_in_1, data_in_2, write_data;
    logic        write_enable;

    logic [63:0] regs [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [63:0] pl_val = '0;

    int tests_run = 0;
    int tests_failed = 0;

    clarvi_slice_alu_seq dut (
        .clock            (clk),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .rs1              (rs1),
        .rs2              (rs2),
        .rd               (rd),
        .busy             (busy),
        .done             (done),
        .flag_zero        (flag_zero),
        .flag_carry       (flag_carry),
        .fetch_part       (fetch_part),
        .fetch_register_1 (fetch_register_1),
        .fetch_register_2 (fetch_register_2),
        .data_in_1        (data_in_1),
        .data_in_2        (data_in_2),
        .write_part       (write_part),
        .write_register   (write_register),
        .write_data       (write_data),
        .write_enable     (write_enable)
    );

    always #5 clk = ~clk;

    // Regfile model: combinational part read, x0 reads zero, write on posedge.
    assign data_in_1 = (fetch_register_1 == 5'd0) ? 16'h0 : regs[fetch_register_1][{fetch_part, 4'b0000} +: 16];
    assign data_in_2 = (fetch_register_2 == 5'd0) ? 16'h0 : regs[fetch_register_2][{fetch_part, 4'b0000} +: 16];

    always @(posedge clk) begin
        if (pl_en)
            regs[pl_idx] <= pl_val;
        else if (write_enable && write_register != 5'd0)
            regs[write_register][{write_part, 4'b0000} +: 16] <= write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [63:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; rd = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples each cycle after acceptance; stops at done or after max cycles.
    task automatic watch(input int max, output int we_cnt, output int we_first, output int done_cyc);
        we_cnt = 0; we_first = -1; done_cyc = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (write_enable) begin
                we_cnt++;
                if (we_first < 0) we_first = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    int we_cnt, we_first, done_cyc;
    int we_seen;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_we", {63'd0, write_enable}, 64'd0);
        check("rst_flags", {62'd0, flag_zero, flag_carry}, 64'd0);
        check("rst_fetch", {57'd0, fetch_part, fetch_register_1}, 64'd0);
        reset = 1'b0;

        // ADD with carry out of part 0
        preload(5'd3, 64'h0000_0000_0000_FFFF);
        preload(5'd4, 64'h1);
        preload(5'd5, 64'hDEAD_BEEF_DEAD_BEEF);
        issue(OP_ADD, 5'd3, 5'd4, 5'd5);
        check("add_busy", {63'd0, busy}, 64'd1);
        watch(20, we_cnt, we_first, done_cyc);
        check("add_done_cyc", done_cyc, 5);
        check("add_we_cnt", we_cnt, 4);
        check("add_we_first", we_first, 1);
        check("add_busy_at_done", {63'd0, busy}, 64'd0);
        check("add_result", regs[5], 64'h0000_0000_0001_0000);
        check("add_flags", {62'd0, flag_zero, flag_carry}, 64'd0);

        // SUB 0 - 1
        preload(5'd1, 64'h0);
        preload(5'd2, 64'h1);
        issue(OP_SUB, 5'd1, 5'd2, 5'd9);
        watch(20, we_cnt, we_first, done_cyc);
        check("sub_result", regs[9], 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_carry", {63'd0, flag_carry}, 64'd0);
        check("sub_zero", {63'd0, flag_zero}, 64'd0);

        // SUB 7 - 7
        preload(5'd10, 64'd7);
        preload(5'd11, 64'd7);
        preload(5'd12, 64'h1234_5678_9ABC_DEF0);
        issue(OP_SUB, 5'd10, 5'd11, 5'd12);
        watch(20, we_cnt, we_first, done_cyc);
        check("sub0_result", regs[12], 64'h0);
        check("sub0_flags", {62'd0, flag_zero, flag_carry}, 64'd3);

        // SLT -1 < 1
        preload(5'd13, 64'hFFFF_FFFF_FFFF_FFFF);
        preload(5'd14, 64'h5555_5555_5555_5555);
        issue(OP_SLT, 5'd13, 5'd2, 5'd14);
        watch(20, we_cnt, we_first, done_cyc);
        check("slt_done_cyc", done_cyc, 9);
        check("slt_we_first", we_first, 5);
        check("slt_we_cnt", we_cnt, 4);
        check("slt_result", regs[14], 64'd1);

        // SLTU same operands
        preload(5'd15, 64'h5555_5555_5555_5555);
        issue(OP_SLTU, 5'd13, 5'd2, 5'd15);
        watch(20, we_cnt, we_first, done_cyc);
        check("sltu_done_cyc", done_cyc, 9);
        check("sltu_result", regs[15], 64'd0);

        // Full aliasing with carry propagation
        preload(5'd5, 64'h0001_0002_0003_8000);
        issue(OP_ADD, 5'd5, 5'd5, 5'd5);
        watch(20, we_cnt, we_first, done_cyc);
        check("alias_result", regs[5], 64'h0002_0004_0007_0000);

        // rd = x0 with start pulsed while busy
        issue(OP_ADD, 5'd3, 5'd4, 5'd0);
        we_seen = 0; done_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 2 || c == 3);
            if (write_enable) we_seen++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        check("rd0_done_cyc", done_cyc, 5);
        check("rd0_we", we_seen, 0);
        @(negedge clk);
        check("rd0_no_reaccept", {63'd0, busy}, 64'd0);

        // Reset sampled at end of cycle 2: parts 0-1 written, 2-3 untouched
        preload(5'd6, 64'h1111_2222_3333_4444);
        preload(5'd7, 64'h0001_0001_0001_0001);
        preload(5'd8, 64'hAAAA_BBBB_CCCC_DDDD);
        issue(OP_ADD, 5'd6, 5'd7, 5'd8);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_we", {63'd0, write_enable}, 64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        we_seen = 0; done_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (write_enable) we_seen++;
            if (done) done_cyc = c;
        end
        check("rst_mid_no_done", done_cyc, -1);
        check("rst_mid_no_we", we_seen, 0);
        check("rst_mid_result", regs[8], 64'hAAAA_BBBB_3334_4445);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
